// File: rtl/btn_conditioner.sv
// Button conditioner: 2-flop synchroniser, counter-based debounce FSM, press/release pulses.
// Optional long-press pulse enabled by defining BTN_LONG_PRESS_EN.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned CNT_WIDTH       = 21,
  parameter int unsigned LONG_CYCLES     = 125000000,
  parameter int unsigned LONG_WIDTH      = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 r_s1;
  logic                 r_s2;
  logic                 w_sync;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_level;
  logic                 r_press;
  logic                 r_release;
  logic                 w_level_nxt;
  logic                 w_press_nxt;
  logic                 w_release_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
    end
  end

  assign w_sync = r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Counter is compared before increment and reloaded on each entry to a counting state.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sync) begin
          w_state_nxt = ARMING;
          w_cnt_nxt   = '0;
        end
      end
      ARMING: begin
        if (!w_sync) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      PRESSED: begin
        if (!w_sync) begin
          w_state_nxt = RELEASING;
          w_cnt_nxt   = '0;
        end
      end
      RELEASING: begin
        if (w_sync) begin
          w_state_nxt = PRESSED;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = IDLE;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASING);
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [LONG_WIDTH-1:0] HOLD_SAT = LONG_WIDTH'(LONG_CYCLES);

  logic [LONG_WIDTH-1:0] r_hold;
  logic [LONG_WIDTH-1:0] w_hold_nxt;
  logic                  r_long;
  logic                  w_long_nxt;

  // Hold counter saturates one past the trigger value so the pulse fires once per press.
  always_comb begin
    w_hold_nxt = r_hold;
    w_long_nxt = 1'b0;
    if (w_state_nxt == IDLE) begin
      w_hold_nxt = '0;
    end else if (r_state == ARMING && w_state_nxt == PRESSED) begin
      w_hold_nxt = '0;
    end else if (r_state == PRESSED && r_hold != HOLD_SAT) begin
      w_hold_nxt = r_hold + LONG_WIDTH'(1);
      w_long_nxt = (r_hold == HOLD_SAT - LONG_WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_hold <= w_hold_nxt;
      r_long <= w_long_nxt;
    end
  end

  assign long_pulse = r_long;
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: a sliding-window reference predicts outputs per cycle.
module tb_btn_conditioner;

  localparam int D = 4;
  localparam int L = 10;
`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic btn   = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (3),
    .LONG_CYCLES    (L),
    .LONG_WIDTH     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  int checks   = 0;
  int failures = 0;

  logic [3:0]  sb_q[$];
  logic [15:0] hist;
  logic        m_level;
  int          m_hold;
  int          step_no;
  int          n_press, n_release, n_long;
  int          press_at, release_at, long_at;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raw samples b[m-2]..b[m-2-D] all equal v: the debounce window feeding the FSM.
  function automatic bit win_all(input logic v);
    bit r = 1'b1;
    for (int unsigned k = 2; k <= 2 + D; k++)
      if (hist[k] !== v) r = 1'b0;
    return r;
  endfunction

  task automatic clear_counts();
    n_press = 0; n_release = 0; n_long = 0;
    press_at = -1; release_at = -1; long_at = -1;
    step_no = 0;
  endtask

  task automatic step(input logic b, input string tag);
    logic ep, er, el;
    logic [3:0] e, got;
    btn  = b;
    hist = {hist[14:0], b};
    ep = !m_level && win_all(1'b1);
    er = m_level && win_all(1'b0);
    el = 1'b0;
    if (ep) m_hold = 0;
    else if (m_level && hist[3] && m_hold != L) begin
      el = LONG_EN && (m_hold == L - 1);
      m_hold++;
    end
    if (er) m_hold = 0;
    if (ep) m_level = 1'b1;
    else if (er) m_level = 1'b0;
    sb_q.push_back({m_level, ep, er, el});
    @(posedge clk);
    #1;
    step_no++;
    got = {btn_level, press_pulse, release_pulse, long_pulse};
    e = sb_q.pop_front();
    check_eq(tag, 32'(got), 32'(e));
    if (press_pulse)   begin n_press++;   if (press_at < 0)   press_at   = step_no; end
    if (release_pulse) begin n_release++; if (release_at < 0) release_at = step_no; end
    if (long_pulse)    begin n_long++;    if (long_at < 0)    long_at    = step_no; end
    @(negedge clk);
  endtask

  task automatic run(input logic b, input int n, input string tag);
    for (int i = 0; i < n; i++) step(b, tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_eq(tag, 32'({btn_level, press_pulse, release_pulse, long_pulse}), 32'h0);
    hist    = '0;
    m_level = 1'b0;
    m_hold  = 0;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    hist = '0; m_level = 1'b0; m_hold = 0;
    clear_counts();
    @(negedge clk);
    do_reset("reset_init");

    clear_counts();
    run(1'b1, 45, "press_hold");
    check_eq("press_count", 32'(n_press), 32'd1);
    check_eq("press_latency", 32'(press_at), 32'd7);
    check_eq("long_count", 32'(n_long), LONG_EN ? 32'd1 : 32'd0);
    if (LONG_EN) check_eq("long_latency", 32'(long_at - press_at), 32'd10);

    clear_counts();
    run(1'b0, 2, "rel_bounce");
    run(1'b1, 8, "rel_bounce");
    check_eq("bounce_release", 32'(n_release), 32'd0);
    check_eq("bounce_press", 32'(n_press), 32'd0);
    check_eq("bounce_level", 32'(btn_level), 32'd1);

    clear_counts();
    run(1'b0, 12, "release");
    check_eq("release_count", 32'(n_release), 32'd1);
    check_eq("release_latency", 32'(release_at), 32'd7);
    check_eq("release_level", 32'(btn_level), 32'd0);

    clear_counts();
    run(1'b1, 3, "glitch");
    run(1'b0, 10, "glitch");
    check_eq("glitch_press", 32'(n_press), 32'd0);
    check_eq("glitch_release", 32'(n_release), 32'd0);

    run(1'b1, 4, "arming");
    do_reset("reset_arming");
    clear_counts();
    run(1'b1, 12, "rearm");
    check_eq("rearm_press_count", 32'(n_press), 32'd1);
    check_eq("rearm_press_latency", 32'(press_at), 32'd7);

    do_reset("reset_pressed");
    clear_counts();
    run(1'b1, 20, "held_reset");
    check_eq("held_press_count", 32'(n_press), 32'd1);
    check_eq("held_press_latency", 32'(press_at), 32'd7);
    run(1'b0, 10, "final_release");
    check_eq("final_release_count", 32'(n_release), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
